// File: rtl/act_mon_pkg.sv
// Shared types and width helpers for the switching-activity monitor.
package act_mon_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_WINDOW     = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    // Enough bits to hold DATA_W toggles on every cycle of a full window.
    function automatic int tog_w(input int data_w, input int window);
        return $clog2(data_w * window + 1);
    endfunction

    // Enough bits to hold the largest single-cycle toggle count.
    function automatic int pk_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Record field widths follow the default bus/window sizes.
    localparam int REC_TOG_W = tog_w(DEF_DATA_W, DEF_WINDOW);
    localparam int REC_PK_W  = pk_w(DEF_DATA_W);

    typedef struct packed {
        logic [7:0]           idx;
        logic [REC_TOG_W-1:0] toggles;
        logic [REC_PK_W-1:0]  peak;
    } act_rec_t;

endpackage

// File: rtl/act_fifo.sv
// First-word fall-through record FIFO. A push into a full FIFO is taken
// only when a pop happens on the same edge; otherwise it is ignored and
// the caller decides what to do about the lost record.
module act_fifo
    import act_mon_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  act_rec_t wdata,
    input  logic     pop,
    output act_rec_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    act_rec_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head record is driven straight from storage; zero while empty.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/act_monitor.sv
// Switching-activity monitor: counts bit toggles on the sampled bus over
// fixed windows of enabled cycles and queues one record per window.
// Output handshake: a record transfers on any rising edge where
// out_valid && out_ready; out_* stay stable while out_valid && !out_ready,
// and out_ready has no effect while out_valid is low.
module act_monitor
    import act_mon_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int TOG_W     = tog_w(DATA_W, WINDOW),
    localparam int PK_W      = pk_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] debug,
    input  logic              en_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_idx,
    output logic [TOG_W-1:0]  out_toggles,
    output logic [PK_W-1:0]   out_peak,
    output logic              overflow_o,
    output logic [7:0]        drop_cnt_o
);

    localparam int CW = $clog2(WINDOW);

    function automatic logic [PK_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [PK_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_W; i++) cnt = cnt + PK_W'(v[i]);
        return cnt;
    endfunction

    logic [DATA_W-1:0] prev;
    logic              primed;
    logic [CW-1:0]     cyc_cnt;
    logic [TOG_W-1:0]  acc;
    logic [PK_W-1:0]   peak;
    logic [7:0]        win_idx;

    logic [PK_W-1:0]   t;
    logic [TOG_W-1:0]  acc_sum;
    logic [PK_W-1:0]   peak_max;
    logic              win_close;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    act_rec_t          rec_in;
    act_rec_t          rec_out;

    // The first sample after reset only primes prev and contributes nothing.
    assign t         = primed ? popcount(debug ^ prev) : '0;
    assign acc_sum   = acc + TOG_W'(t);
    assign peak_max  = (t > peak) ? t : peak;
    assign win_close = en_i && (cyc_cnt == CW'(WINDOW - 1));

    assign rec_in.idx     = win_idx;
    assign rec_in.toggles = REC_TOG_W'(acc_sum);
    assign rec_in.peak    = REC_PK_W'(peak_max);

    assign push = win_close;
    assign pop  = out_valid && out_ready;
    assign drop = push && full && !pop;

    // Sampling, accumulation and window sequencing; holds while en_i is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            primed  <= 1'b0;
            cyc_cnt <= '0;
            acc     <= '0;
            peak    <= '0;
            win_idx <= '0;
        end else if (en_i) begin
            prev   <= debug;
            primed <= 1'b1;
            if (win_close) begin
                cyc_cnt <= '0;
                acc     <= '0;
                peak    <= '0;
                win_idx <= win_idx + 8'd1;
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
                acc     <= acc_sum;
                peak    <= peak_max;
            end
        end
    end

    // Lost-record tracking: sticky flag plus saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

    act_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (rec_in),
        .pop   (pop),
        .rdata (rec_out),
        .full  (full),
        .empty (empty)
    );

    assign out_valid   = !empty;
    assign out_idx     = rec_out.idx;
    assign out_toggles = TOG_W'(rec_out.toggles);
    assign out_peak    = PK_W'(rec_out.peak);

endmodule

// File: tb/tb_act_monitor.sv
// Self-checking bench for act_monitor: a queue-based window/FIFO model
// checked every cycle, plus literal expectations for the directed cases.
module tb_act_monitor;

  localparam int DW    = 16;
  localparam int WIN   = 16;
  localparam int DEPTH = 4;
  localparam int TW    = 9;
  localparam int PW    = 5;
  localparam int RW    = 8 + TW + PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] debug = '0;
  logic          en_i = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_idx;
  logic [TW-1:0] out_toggles;
  logic [PW-1:0] out_peak;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  act_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .debug       (debug),
    .en_i        (en_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_toggles (out_toggles),
    .out_peak    (out_peak),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each completed window is the list of its per-cycle toggle counts;
  // the record is that list's sum and max. Queued records live in exp_q.
  logic [RW-1:0] exp_q[$];
  int            m_win_t[$];
  logic [DW-1:0] m_prev;
  bit            m_primed;
  int            m_idx;
  int            m_drops;
  int            m_t;
  int            m_sum;
  int            m_mx;
  bit            m_popped;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_win_t.delete();
      m_prev   = '0;
      m_primed = 1'b0;
      m_idx    = 0;
      m_drops  = 0;
    end else begin
      m_popped = (exp_q.size() > 0) && out_ready;
      if (m_popped) void'(exp_q.pop_front());
      if (en_i) begin
        m_t = m_primed ? $countones(debug ^ m_prev) : 0;
        m_prev = debug;
        m_primed = 1'b1;
        m_win_t.push_back(m_t);
        if (m_win_t.size() == WIN) begin
          m_sum = 0;
          m_mx  = 0;
          foreach (m_win_t[i]) begin
            m_sum += m_win_t[i];
            if (m_win_t[i] > m_mx) m_mx = m_win_t[i];
          end
          if (exp_q.size() < DEPTH) exp_q.push_back({8'(m_idx), 9'(m_sum), 5'(m_mx)});
          else m_drops++;
          m_idx = (m_idx + 1) % 256;
          m_win_t.delete();
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (checking && !rst) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("out_idx", 32'(out_idx), 32'(exp_q[0][RW-1 -: 8]));
        check("out_toggles", 32'(out_toggles), 32'(exp_q[0][PW +: TW]));
        check("out_peak", 32'(out_peak), 32'(exp_q[0][PW-1:0]));
      end
      check("overflow_o", 32'(overflow_o), 32'(m_drops > 0));
      check("drop_cnt_o", 32'(drop_cnt_o), (m_drops > 255) ? 32'd255 : 32'(m_drops));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [DW-1:0] d, input logic rdy);
    @(negedge clk);
    en_i = en;
    debug = d;
    out_ready = rdy;
  endtask

  task automatic idle();
    drive(1'b0, debug, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en_i = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_toggles", 32'(out_toggles), 32'd0);
    check("rst_peak", 32'(out_peak), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic alt_window(input logic rdy);
    for (int i = 0; i < WIN; i++) drive(1'b1, (i % 2 == 1) ? 16'hFFFF : 16'h0000, rdy);
  endtask

  task automatic rand_enabled(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, 16'($urandom_range(0, 65535)), rdy);
  endtask

  task automatic expect_head(input string name, input int idx, input int tog, input int pk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_idx"}, 32'(out_idx), 32'(idx));
    check({name, "_toggles"}, 32'(out_toggles), 32'(tog));
    check({name, "_peak"}, 32'(out_peak), 32'(pk));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    checking = 1'b1;

    // Alternating bus: 15 counted transitions of 16 bits.
    alt_window(1'b0);
    idle();
    expect_head("alt", 0, 240, 16);
    drive(1'b0, debug, 1'b1);

    // Constant bus over two windows.
    do_reset();
    for (int i = 0; i < 2 * WIN; i++) drive(1'b1, 16'h1234, 1'b0);
    idle();
    expect_head("const0", 0, 0, 0);
    drive(1'b0, debug, 1'b1);
    idle();
    expect_head("const1", 1, 0, 0);

    // Five windows with no consumer: one dropped, idx gap afterwards.
    do_reset();
    rand_enabled(5 * WIN, 1'b0);
    idle();
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_cnt", 32'(drop_cnt_o), 32'd1);
    check("ovf_head", 32'(out_idx), 32'd0);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, debug, 1'b1);
    idle();
    check("ovf_drained", 32'(out_valid), 32'd0);
    rand_enabled(WIN, 1'b0);
    idle();
    check("ovf_next_idx", 32'(out_idx), 32'd5);

    // Pause mid-window with the bus changing; enabled samples still alternate.
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      drive(1'b1, (i % 2 == 1) ? 16'hFFFF : 16'h0000, 1'b0);
      if (i == 7)
        for (int j = 0; j < 10; j++) drive(1'b0, 16'($urandom_range(0, 65535)), 1'b0);
    end
    idle();
    expect_head("pause", 0, 240, 16);

    // Full FIFO with ready on the closing cycle: push accepted, no drop.
    do_reset();
    rand_enabled(4 * WIN + WIN - 1, 1'b0);
    drive(1'b1, 16'($urandom_range(0, 65535)), 1'b1);
    idle();
    check("full_pp_ovf", 32'(overflow_o), 32'd0);
    check("full_pp_head", 32'(out_idx), 32'd1);

    // Reset mid-window with two records queued.
    do_reset();
    rand_enabled(2 * WIN + 5, 1'b0);
    do_reset();
    alt_window(1'b0);
    idle();
    expect_head("post_rst", 0, 240, 16);

    // Random traffic on all inputs.
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 2) == 0));
    idle();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/act_monitor.md
# act_monitor

Switching-activity monitor for the power-modeling flow. It samples the CPU's 16-bit `debug` bus every enabled cycle and counts bit toggles between consecutive samples. Toggles are accumulated over fixed windows of cycles. Each completed window becomes a record queued in a small FIFO, and a downstream consumer (trace dumper or power estimator) drains the FIFO over a valid/ready port. The block sits directly downstream of `cpu` and consumes `debug` alongside the testbench.

## Interface
- `DATA_W`, 16, width of the sampled bus
- `WINDOW`, 16, enabled cycles per window (≥2)
- `FIFO_DEPTH`, 4, record FIFO entries (power of 2, ≥2)
- `clk` in 1, single clock; all state updates on posedge
- `rst` in 1, reset, asynchronous, active-high; clears all state
- `debug` in DATA_W, bus under observation, from `cpu`
- `en_i` in 1, sample enable
- `out_valid` out 1, FIFO non-empty
- `out_ready` in 1, consumer accepts head record
- `out_idx` out 8, window index of head record
- `out_toggles` out TOG_W, total toggles in the window; TOG_W = clog2(DATA_W*WINDOW+1), 9 at defaults
- `out_peak` out PK_W, max single-cycle toggles in the window; PK_W = clog2(DATA_W+1), 5 at defaults
- `overflow_o` out 1, sticky: a record was dropped
- `drop_cnt_o` out 8, dropped records, saturating at 255

## Operation
- State cleared by reset: `prev`, `primed`=0, `cyc_cnt`=0, `acc`=0, `peak`=0, `win_idx`=0.
- Outputs at reset: FIFO empty, so `out_valid`=0 and `out_idx`/`out_toggles`/`out_peak`=0. `overflow_o`=0 and `drop_cnt_o`=0.
- **Enabled cycle** (`en_i`=1):
  - t = popcount(`debug` XOR `prev`), or 0 when `primed`=0.
  - Updates: `prev`←`debug`, `primed`←1, `acc`+=t, `peak`=max(`peak`,t), `cyc_cnt`++.
  - The priming cycle still counts as a window cycle.
- **`en_i`=0:** no sample. `prev`, `primed`, `cyc_cnt`, `acc` and `peak` all hold, so the window pauses.
- **Window close** (enabled cycle with `cyc_cnt`==WINDOW-1):
  - Push record {`win_idx`, `acc`+t, max(`peak`,t)}, including this cycle's t.
  - Then `acc`←0, `peak`←0, `cyc_cnt`←0, `win_idx`++ (8-bit wrap, 255→0).
  - `win_idx` increments even if the record is dropped, so gaps in `out_idx` reveal the loss.
- **FIFO:** first-word fall-through. The head record is driven combinationally from storage and pops on `out_valid && out_ready`.
- **Push while full:**
  - Accepted if a pop occurs in the same cycle.
  - Otherwise the record is dropped: `overflow_o`←1 (sticky until reset) and `drop_cnt_o`++ (saturating).
- Push and pop together when not full: both occur; occupancy is unchanged.
- `out_ready` while `out_valid`=0 has no effect.
- No arithmetic overflow is possible: TOG_W covers the DATA_W×WINDOW maximum.

## Timing
- Sample to accumulator: same edge; `acc` reflects the sample one cycle later.
- Window close to `out_valid`: a record pushed at edge N is visible after edge N (`out_valid`=1 in cycle N+1), when the FIFO was empty.
- Pop at edge M: the next record (or `out_valid`=0) appears after edge M.
- `out_*` hold stable while `out_valid && !out_ready`.
- Reset asserted mid-window or with the FIFO partly full: all state clears immediately (async). Pending records are lost and the `overflow_o` flag clears.
- Reset deasserted: the first enabled cycle primes; the next record has `out_idx`=0.

## Structure
- Package `act_mon_pkg`:
  - `act_rec_t` packed struct {idx[7:0], toggles[TOG_W-1:0], peak[PK_W-1:0]}
  - width helper functions for TOG_W and PK_W
  - default parameter constants
- Sub-module `act_fifo`:
  - parameterized sync FIFO of `act_rec_t`, FWFT
  - ports: push/pop, full/empty, concurrent push+pop when full
  - same `clk`/`rst` convention as the top
- Top: popcount (combinational function), window counter/accumulator, drop/overflow logic.

## Test plan
- Alternating `debug` 0x0000/0xFFFF, `en_i`=1 for 16 cycles after reset → one record: idx 0, toggles 240 (15×16; first cycle primes), peak 16.
- Constant `debug`=0x1234 for 32 enabled cycles → records idx 0 and 1, each toggles 0, peak 0.
- `out_ready`=0 and 5 windows complete → 4 records (idx 0–3) retained, `overflow_o`=1, `drop_cnt_o`=1. After draining, the next window's record has idx 5.
- `en_i` low for 10 cycles mid-window with `debug` changing → no toggles counted and the window closes after 16 enabled cycles total. The first sample after re-enable compares against the last enabled sample.
- FIFO full with `out_ready`=1 on the window-close cycle → push accepted, `overflow_o` stays 0, occupancy stays 4.
- `rst` pulsed mid-window with 2 records queued → `out_valid`=0 immediately, counters zero, and the next record has idx 0 with priming applied.
